// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and serializes each one
// as a UART frame (start bit, WIDTH data bits LSB first, one stop bit).
// tx, busy and tx_done are registered; fifo_rd is a combinational strobe
// decoded from the IDLE state so the FIFO is only ever read between frames.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [BAUD_W-1:0] baud_q,    baud_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic [WIDTH-1:0]  shift_q,   shift_d;
    logic              tx_q,      tx_d;
    logic              busy_q,    busy_d;
    logic              tx_done_q, tx_done_d;
    logic              bit_end;

    // Read strobe: only from IDLE, and held off while reset is asserted.
    assign fifo_rd = (state_q == S_IDLE) && !fifo_empty && !rst;

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

    // Next-state logic for the frame sequencer, baud/bit counters and shifter.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_done_d = 1'b0;
        bit_end   = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (fifo_rd) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // FIFO data is valid one cycle after the read strobe.
                shift_d = fifo_dout;
                bit_d   = '0;
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d    = '0;
                    state_d   = S_IDLE;
                    tx_done_d = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end else begin
            tx_d = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: behavioural FIFO front end, frame timeline
// checks relative to each read strobe, and a word scoreboard.
module tb_fifo_uart_tx;

    localparam int W     = 8;
    localparam int C     = 4;
    localparam int F_END = 1 + C * (W + 2);   // last STOP cycle, relative to fifo_rd
    localparam int DONE  = F_END + 1;         // tx_done cycle

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_dout = '0;
    logic         fifo_rd;
    logic         tx;
    logic         busy;
    logic         tx_done;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] frame_word;
    logic [W-1:0] rx_word;
    logic [W-1:0] exp_word;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int last_rd = -1;
    int rd_count = 0;
    int done_count = 0;
    int frame_no = 0;
    bit frame_active = 0;
    bit toggle_en = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic exp_tx(input int r, input logic [W-1:0] w);
        if (r <= 1)               return 1'b1;
        else if (r <= 1 + C)      return 1'b0;
        else if (r <= 1 + C*(W+1)) return w[(r - 2 - C) / C];
        else                      return 1'b1;
    endfunction

    // One clock cycle: check outputs at the falling edge, then advance the FIFO model.
    task automatic tick();
        int  rel;
        bit  rd_seen;
        rd_seen = 0;
        rel = 0;
        @(negedge clk);
        cyc++;
        if (frame_active) rel = cyc - t0;
        if (frame_active && rel <= F_END) begin
            check("tx", tx, exp_tx(rel, frame_word));
            check("busy", busy, 1);
            check("tx_done_mid", tx_done, 0);
            check("rd_in_frame", fifo_rd, 0);
            if (rel >= 2 + C && rel <= 1 + C*(W+1) && ((rel - 2 - C) % C) == 2)
                rx_word[(rel - 2 - C) / C] = tx;
        end else begin
            if (frame_active) begin
                check("tx_done", tx_done, 1);
                check("tx_gap", tx, 1);
                check("busy_done", busy, 0);
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("scoreboard", rx_word, exp_word);
                $display("frame %0d: received %02h expected %02h at cycle %0d",
                         frame_no, rx_word, exp_word, cyc);
                frame_no++;
                done_count++;
                frame_active = 0;
            end else begin
                check("tx_done_idle", tx_done, 0);
                check("tx_idle", tx, 1);
                check("busy_idle", busy, 0);
            end
            check("rd_idle", fifo_rd, !fifo_empty && !rst);
        end
        if (fifo_rd) begin
            rd_count++;
            if (last_rd >= 0) check("rd_spacing", cyc - last_rd, DONE);
            last_rd = cyc;
            frame_active = 1;
            t0 = cyc;
            frame_word = (fifo_q.size() > 0) ? fifo_q[0] : 'x;
            rx_word = '0;
            rd_seen = 1;
        end
        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        if (toggle_en && frame_active && (cyc - t0) < F_END - 1)
            fifo_empty = ~fifo_empty;
        else
            fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic load(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((frame_active || fifo_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", n < budget, 1);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic new_scenario();
        last_rd = -1;
        rd_count = 0;
        done_count = 0;
    endtask

    initial begin
        // Reset asserted mid-clock with the FIFO empty.
        #12;
        rst = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rd", fifo_rd, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("idle_rd_count", rd_count, 0);

        // Single word.
        new_scenario();
        load(8'hA5);
        run_until_idle(200);
        check("single_rd_count", rd_count, 1);
        check("single_done_count", done_count, 1);

        // Back-to-back words.
        new_scenario();
        load(8'h01);
        load(8'h80);
        run_until_idle(300);
        check("b2b_rd_count", rd_count, 2);
        check("b2b_done_count", done_count, 2);

        // Empty flag toggling during a frame.
        new_scenario();
        toggle_en = 1;
        load(8'h3C);
        run_until_idle(200);
        toggle_en = 0;
        check("toggle_rd_count", rd_count, 1);

        // Reset during data bit 3 of 0xFF, then 0x55 must go out intact.
        new_scenario();
        load(8'hFF);
        load(8'h55);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (frame_active && (cyc - t0) == 2 + C + 3*C + 1) break;
        end
        check("abort_reached", frame_active, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_tx_done", tx_done, 0);
        check("abort_rd", fifo_rd, 0);
        if (frame_active) begin
            frame_active = 0;
            void'(exp_q.pop_front());
        end
        last_rd = -1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        run_until_idle(200);
        check("abort_done_count", done_count, 1);
        check("abort_rd_count", rd_count, 2);

        // Full drain of 16 words.
        new_scenario();
        for (int i = 0; i < 16; i++) load(W'(i));
        run_until_idle(2000);
        check("drain_rd_count", rd_count, 16);
        check("drain_done_count", done_count, 16);
        for (int i = 0; i < 20; i++) tick();
        check("drain_empty", fifo_empty, 1);
        check("drain_busy", busy, 0);
        check("drain_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
